// File: rtl/motor_cmd_uart_rx_if.sv
// Output bundle of the drive-command UART receiver: received bytes, the decoded
// motor command and the link status flags.
interface motor_cmd_uart_rx_if;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [3:0] direction;
  logic [2:0] speed;
  logic       cmd_valid;
  logic       frame_err;
  logic       link_timeout;

  modport master (
    output rx_byte, byte_valid, direction, speed, cmd_valid, frame_err, link_timeout
  );

  modport slave (
    input rx_byte, byte_valid, direction, speed, cmd_valid, frame_err, link_timeout
  );
endinterface

// File: rtl/motor_cmd_uart_rx.sv
// 8N1 UART receiver and three-byte drive-command frame checker (SYNC, CMD, ~CMD).
// Define MOTOR_RX_WATCHDOG_EN to build in the link watchdog that forces STOP on silence.
module motor_cmd_uart_rx #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CLKS = 50_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                uart_in,
  motor_cmd_uart_rx_if.master rx_if
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DIR_STOP  = 4'd8;

  if (CLKS_PER_BIT < 8 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("motor_cmd_uart_rx: CLKS_PER_BIT must be >= 8 and TIMEOUT_CLKS >= 1");
  end

  // A command byte is legal when its pad bit is clear and the direction is at most STOP.
  function automatic logic cmd_in_range(input logic [7:0] b);
    return (b[3] == 1'b0) && (b[7:4] <= DIR_STOP);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } bit_state_t;

  typedef enum logic [1:0] {
    F_HDR,
    F_CMD,
    F_CHK
  } frm_state_t;

  // Stage p0/p1: two-flop synchroniser; idle-high reset value avoids a false start.
  logic uart_sync_p0;
  logic uart_sync_p1;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      uart_sync_p0 <= 1'b1;
      uart_sync_p1 <= 1'b1;
    end else begin
      uart_sync_p0 <= uart_in;
      uart_sync_p1 <= uart_sync_p0;
    end
  end

  bit_state_t       bit_state;
  bit_state_t       bit_state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift_q;
  logic [7:0]       shift_nxt;
  logic             byte_done;
  logic             stop_err;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_state <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      bit_state <= bit_state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    shift_q <= shift_nxt;
  end

  always_comb begin
    bit_state_nxt = bit_state;
    clk_cnt_nxt   = clk_cnt + 1'b1;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift_q;
    byte_done     = 1'b0;
    stop_err      = 1'b0;
    unique case (bit_state)
      S_IDLE: begin
        clk_cnt_nxt = '0;
        if (!uart_sync_p1) begin
          bit_state_nxt = S_START;
        end
      end
      S_START: begin
        // Mid-start-bit re-check rejects short glitches without flagging an error.
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt   = '0;
          bit_idx_nxt   = '0;
          bit_state_nxt = uart_sync_p1 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {uart_sync_p1, shift_q[7:1]};
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            bit_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nxt = '0;
          if (uart_sync_p1) begin
            byte_done     = 1'b1;
            bit_state_nxt = S_IDLE;
          end else begin
            stop_err      = 1'b1;
            bit_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        clk_cnt_nxt = '0;
        if (uart_sync_p1) begin
          bit_state_nxt = S_IDLE;
        end
      end
      default: begin
        bit_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage p2: byte output register, one cycle after the stop-bit sample.
  frm_state_t frm_state;
  frm_state_t frm_state_nxt;
  logic [7:0] cmd_q;
  logic [7:0] cmd_nxt;
  logic       accept;
  logic       frm_err;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_if.rx_byte    <= '0;
      rx_if.byte_valid <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.cmd_valid  <= 1'b0;
      frm_state        <= F_HDR;
    end else begin
      rx_if.byte_valid <= byte_done;
      if (byte_done) begin
        rx_if.rx_byte <= shift_q;
      end
      rx_if.frame_err <= stop_err | frm_err;
      rx_if.cmd_valid <= accept;
      frm_state       <= frm_state_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    cmd_q <= cmd_nxt;
  end

  always_comb begin
    frm_state_nxt = frm_state;
    cmd_nxt       = cmd_q;
    accept        = 1'b0;
    frm_err       = 1'b0;
    if (rx_if.byte_valid) begin
      unique case (frm_state)
        F_HDR: begin
          if (rx_if.rx_byte == SYNC_BYTE) begin
            frm_state_nxt = F_CMD;
          end
        end
        F_CMD: begin
          if (cmd_in_range(rx_if.rx_byte)) begin
            cmd_nxt       = rx_if.rx_byte;
            frm_state_nxt = F_CHK;
          end else begin
            frm_err       = 1'b1;
            frm_state_nxt = F_HDR;
          end
        end
        F_CHK: begin
          if (rx_if.rx_byte == ~cmd_q) begin
            accept        = 1'b1;
            frm_state_nxt = F_HDR;
          end else begin
            // A failed checksum that looks like a header is treated as the start of a new frame.
            frm_err       = 1'b1;
            frm_state_nxt = (rx_if.rx_byte == SYNC_BYTE) ? F_CMD : F_HDR;
          end
        end
        default: begin
          frm_state_nxt = F_HDR;
        end
      endcase
    end
  end

  // Stage p3: command outputs, aligned with cmd_valid.
`ifdef MOTOR_RX_WATCHDOG_EN
  localparam int              WD_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CLKS);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_LIMIT);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_if.direction    <= '0;
      rx_if.speed        <= '0;
      rx_if.link_timeout <= 1'b0;
    end else if (accept) begin
      rx_if.direction    <= cmd_q[7:4];
      rx_if.speed        <= cmd_q[2:0];
      rx_if.link_timeout <= 1'b0;
    end else if (wd_expired) begin
      rx_if.direction    <= DIR_STOP;
      rx_if.speed        <= '0;
      rx_if.link_timeout <= 1'b1;
    end
  end
`else
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_if.direction <= '0;
      rx_if.speed     <= '0;
    end else if (accept) begin
      rx_if.direction <= cmd_q[7:4];
      rx_if.speed     <= cmd_q[2:0];
    end
  end

  assign rx_if.link_timeout = 1'b0;
`endif

endmodule

// File: doc/motor_cmd_uart_rx.md
# motor_cmd_uart_rx

Receive side of the drive-command serial link. Deserialises the 8N1 UART stream produced on the motor-control pin and validates three-byte command frames. Recovers the direction code and speed level, and drives them to the motor power stage or to a second board. Also serves as a loopback checker on the drive output.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (9600 baud at 50 MHz); minimum 8.
- SYNC_BYTE, 8'hAA: frame header value.
- TIMEOUT_CLKS, 50_000_000: link watchdog period in clocks (used only with the watchdog compiled in).

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- uart_in  input  1  serial line, idle high, asynchronous to CLOCK_50.
- rx_byte  output  8  last received byte.
- byte_valid  output  1  one-cycle pulse when rx_byte updates.
- direction  output  4  decoded direction code: 0 IDLE_BASE … 8 STOP.
- speed  output  3  decoded speed level.
- cmd_valid  output  1  one-cycle pulse when a frame is accepted.
- frame_err  output  1  one-cycle pulse on a framing, range or checksum error.
- link_timeout  output  1  level; high while the watchdog has expired.

## Operation
- Reset values: rx_byte=0, byte_valid=0, direction=0, speed=0, cmd_valid=0, frame_err=0, link_timeout=0. Both FSMs go to their first state and all counters clear.
- uart_in passes through a 2-flop synchroniser. Sampling uses the synchronised signal only.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a low on the line moves to START and clears the counter.
  - START: after CLKS_PER_BIT/2 clocks (integer division), sample the line. Low moves to DATA. High is a glitch: return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT clocks.
    - High: load rx_byte, pulse byte_valid, return to IDLE.
    - Low: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is high, then go to IDLE. This covers a break or a stuck-low line.
- Frame format: SYNC_BYTE, then CMD, then CHK.
  - CMD = {direction[3:0], 1'b0, speed[2:0]}.
  - CHK = ~CMD.
- Frame FSM states: HDR, CMD, CHK. It advances only on byte_valid.
  - HDR: a byte equal to SYNC_BYTE moves to CMD. Any other byte is dropped silently.
  - CMD: latch the byte internally and move to CHK. If bit3=1 or direction>8, pulse frame_err and return to HDR.
  - CHK: if the byte equals ~latched CMD:
    - update direction and speed;
    - pulse cmd_valid;
    - return to HDR.
  - CHK mismatch: pulse frame_err. If the mismatched byte equals SYNC_BYTE, go to CMD (resync). Otherwise go to HDR.
- direction and speed change only on an accepted frame, or on watchdog expiry.
- If reset_n asserts mid-byte or mid-frame, the partial data is lost with no pulse. After release, receive restarts at IDLE/HDR.

## Timing
- byte_valid is high exactly one cycle, on the cycle after the stop-bit sample. Total latency is ≤2 cycles of synchroniser plus CLKS_PER_BIT/2 + 9·CLKS_PER_BIT from the start edge.
- cmd_valid and frame_err (checksum or range) are asserted in the cycle after the byte_valid of the deciding byte. direction and speed take their new values in that same cycle.
- A stop-bit frame_err is asserted in the same cycle that byte_valid would have been.
- Back-to-back bytes with no idle gap are received without loss. The next start edge is detected in IDLE, immediately after STOP.
- byte_valid and frame_err are never high in the same cycle.

## Configuration
- MOTOR_RX_WATCHDOG_EN defined:
  - A counter clears on every cmd_valid.
  - After TIMEOUT_CLKS clocks with no cmd_valid: force direction=8 (STOP) and speed=0, and set link_timeout=1.
  - The next accepted frame clears link_timeout and applies the new command in the same cycle.
  - The counter saturates; it does not wrap.
- Not defined: no counter exists, link_timeout is tied 0, and the last command holds indefinitely.

## Test plan
Bench uses CLKS_PER_BIT=16; TIMEOUT_CLKS=2000 with the watchdog enabled.
- Frame AA, 15, EA: bytes 15 and EA are complements, so expect one cmd_valid with direction=1 and speed=5. Three byte_valid pulses, no frame_err.
- Frame AA, 15, EB: expect frame_err once, no cmd_valid, and direction/speed unchanged. A following frame AA, 24, DB gives direction=2, speed=4.
- 4-clock low glitch on an idle line: no byte_valid and no frame_err. Then byte 0x3C is received correctly.
- Byte with stop bit forced low, line held low 100 clocks, then frame AA, 80, 7F:
  - frame_err on the stop sample, then recovery;
  - direction=8, speed=0, cmd_valid.
- Watchdog: valid frame AA, 12, ED, then 2000 idle clocks.
  - Expect link_timeout=1, direction=8, speed=0.
  - Frame AA, 13, EC then clears link_timeout with direction=1, speed=3.
- reset_n pulsed low mid-CMD byte: all outputs return to reset values at once. A subsequent full frame is accepted normally.
